tx_frame_ctrl: RTL and testbench
================================

Name: tx_frame_ctrl

Overview:
- Transmit-side framer for the 16-bit transceiver link.
- Pops payload words from a show-ahead source FIFO, which is filled by the DRAM/ADC side.
- Wraps each packet as START_WORD, PAYLOAD_LEN data words, END_WORD.
- Drives the transceiver TX parallel interface with data and control-character (datak) flags.
- Emits CONT_WORD instead of an idle gap when the next full packet is already available.
- Inserts K-character idle words at all other times so the far-end receiver keeps word alignment.

Parameters:
- PAYLOAD_LEN, 126, payload words per frame; legal range 121..127 (far-end end-word detection needs >120, and its counter is 7 bits).
- USEDW_WIDTH, 9, width of the source FIFO fill-level input.
- START_WORD, 16'hDEAD, first word of an isolated frame.
- END_WORD, 16'h7FFF, last word of every frame.
- CONT_WORD, 16'hBEEF, replaces the idle gap and START_WORD for a back-to-back frame.
- IDLE_WORD, 16'h50BC, idle/comma word (K28.5 in the low byte).
- IDLE_DATAK, 2'b01, datak value sent with IDLE_WORD.

Ports:
- tx_std_clkout  in  1  TX parallel clock; all logic is in this domain.
- rst  in  1  asynchronous, active-high reset.
- tx_ready  in  1  transceiver TX ready/locked; gates frame start only.
- tx_enable  in  1  permits new frames; when deasserted, the current frame completes.
- src_data  in  16  show-ahead FIFO head word; valid whenever src_empty=0.
- src_empty  in  1  source FIFO empty.
- src_usedw  in  USEDW_WIDTH  source FIFO fill level.
- src_rdreq  out  1  pop strobe; combinational.
- TX_data  out  16  registered word to the transceiver.
- tx_datak  out  2  registered; 2'b00 for every framing/payload word, IDLE_DATAK for idle.
- frame_active  out  1  high while a START/CONT, payload or END word is being driven.
- frame_count  out  16  count of END_WORDs sent; wraps at 16'hFFFF.
- underrun_err  out  1  sticky; set when the source empties mid-payload.
- data_clamped  out  1  sticky; set when a payload word was substituted.

Behaviour:
- Reset (async, immediate): TX_data=IDLE_WORD, tx_datak=IDLE_DATAK, src_rdreq=0, frame_active=0, frame_count=0, underrun_err=0, data_clamped=0, state=IDLE, word counter=0.
  - A partial frame in flight is abandoned and no further pops occur.
  - The far end resynchronises on the next START_WORD.
- Launch condition: L = tx_ready & tx_enable & (src_usedw >= PAYLOAD_LEN).
- All of TX_data, tx_datak and frame_active are registered: the value chosen in state S appears after the edge that ends S.
- IDLE: drive the idle word. If L, go to HEADER with hdr=START_WORD.
- HEADER: drive hdr with datak 00, clear word counter, go to PAYLOAD.
- PAYLOAD:
  - src_rdreq = !src_empty.
  - On a pop, drive src_data with datak 00 and increment the counter.
  - If src_data==END_WORD, drive END_WORD-1 (16'h7FFE) instead and set data_clamped.
  - If src_empty=1, drive the idle word with IDLE_DATAK, hold the counter, set underrun_err, and stay in PAYLOAD. The far end ignores datak!=00 words.
  - On the pop that makes counter==PAYLOAD_LEN, go to TRAILER.
- TRAILER: drive END_WORD with datak 00 and increment frame_count.
  - Evaluate L in this same cycle.
  - If L: go to HEADER with hdr=CONT_WORD. The output stream is then ...7FFF, BEEF, P0..., with zero idle words between frames.
  - Otherwise go to IDLE; at least one idle word follows the END_WORD.
- Latency: L sampled high in IDLE gives START_WORD on TX_data 1 edge later, and P0 2 edges later. Best-case frame length is PAYLOAD_LEN+2 cycles.
- Width/wrap rules:
  - The word counter is wide enough for PAYLOAD_LEN and resets per frame.
  - frame_count wraps 16'hFFFF -> 0.
  - The sticky flags clear only on rst.
- Simultaneous and mid-frame events:
  - Deasserting tx_enable or tx_ready mid-frame does not truncate the frame. It only affects the next L evaluation.
  - src_usedw is used only for the launch decision. Pops track src_empty.
  - src_rdreq is never asserted outside PAYLOAD, and never while src_empty=1.

Test Plan:
- Reset, tx_ready=tx_enable=1, preload FIFO with 126 words 0x0000..0x007D -> one idle word minimum, then DEAD, 0x0000..0x007D, 7FFF, then idle 50BC/01; frame_count=1; exactly 126 pops.
- Preload 252 words -> 7FFF immediately followed by BEEF then the second payload; frame_count=2; no idle between frames.
- Preload 125 words -> stays idle with no pops; pushing a 126th word gives DEAD 2 edges after usedw reaches 126.
- Start a frame with only 126 words, let the FIFO empty at word 60, refill 3 cycles later -> 3 idle 50BC/01 words mid-payload, underrun_err=1, payload still 126 data words, then 7FFF.
- Payload containing 16'h7FFF at index 10 -> 16'h7FFE sent at that slot; data_clamped=1; framing intact.
- Assert rst at payload word 40 -> outputs idle 50BC/01 immediately (before the next edge), src_rdreq=0, all counters and flags cleared; after release a full new frame begins with DEAD.

Source files
------------

// File: rtl/tx_frame_ctrl.sv
// rtl/tx_frame_ctrl.sv - transmit framer: START/CONT header, fixed-length payload, END trailer, K-char idle fill
module tx_frame_ctrl #(
    parameter int          PAYLOAD_LEN = 126,
    parameter int          USEDW_WIDTH = 9,
    parameter logic [15:0] START_WORD  = 16'hDEAD,
    parameter logic [15:0] END_WORD    = 16'h7FFF,
    parameter logic [15:0] CONT_WORD   = 16'hBEEF,
    parameter logic [15:0] IDLE_WORD   = 16'h50BC,
    parameter logic [1:0]  IDLE_DATAK  = 2'b01
) (
    input  logic                   tx_std_clkout,
    input  logic                   rst,
    input  logic                   tx_ready,
    input  logic                   tx_enable,
    input  logic [15:0]            src_data,
    input  logic                   src_empty,
    input  logic [USEDW_WIDTH-1:0] src_usedw,
    output logic                   src_rdreq,
    output logic [15:0]            TX_data,
    output logic [1:0]             tx_datak,
    output logic                   frame_active,
    output logic [15:0]            frame_count,
    output logic                   underrun_err,
    output logic                   data_clamped
);
    localparam int                     CNT_W     = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CNT_W-1:0]       LEN_CNT   = CNT_W'(PAYLOAD_LEN);
    localparam logic [USEDW_WIDTH-1:0] LEN_USEDW = USEDW_WIDTH'(PAYLOAD_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_TRAILER
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      hdr_q, hdr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      data_q, data_d;
    logic [1:0]       datak_q, datak_d;
    logic             active_q, active_d;
    logic [15:0]      fcount_q, fcount_d;
    logic             underrun_q, underrun_d;
    logic             clamped_q, clamped_d;
    logic             launch;

    // A frame only starts when a whole payload is already buffered, so the
    // payload normally streams out without gaps.
    assign launch = tx_ready & tx_enable & (src_usedw >= LEN_USEDW);

    always_ff @(posedge tx_std_clkout or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hdr_q      <= START_WORD;
            cnt_q      <= '0;
            data_q     <= IDLE_WORD;
            datak_q    <= IDLE_DATAK;
            active_q   <= 1'b0;
            fcount_q   <= '0;
            underrun_q <= 1'b0;
            clamped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            datak_q    <= datak_d;
            active_q   <= active_d;
            fcount_q   <= fcount_d;
            underrun_q <= underrun_d;
            clamped_q  <= clamped_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        cnt_d      = cnt_q;
        data_d     = IDLE_WORD;
        datak_d    = IDLE_DATAK;
        active_d   = 1'b0;
        fcount_d   = fcount_q;
        underrun_d = underrun_q;
        clamped_d  = clamped_q;
        src_rdreq  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_HEADER;
                    hdr_d   = START_WORD;
                end
            end
            S_HEADER: begin
                data_d   = hdr_q;
                datak_d  = 2'b00;
                active_d = 1'b1;
                cnt_d    = '0;
                state_d  = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                active_d = 1'b1;
                if (!src_empty) begin
                    src_rdreq = 1'b1;
                    datak_d   = 2'b00;
                    cnt_d     = cnt_q + 1'b1;
                    // A payload END_WORD would end the frame early at the far end.
                    if (src_data == END_WORD) begin
                        data_d    = END_WORD - 16'd1;
                        clamped_d = 1'b1;
                    end else begin
                        data_d = src_data;
                    end
                    if (cnt_d == LEN_CNT) begin
                        state_d = S_TRAILER;
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end
            S_TRAILER: begin
                data_d   = END_WORD;
                datak_d  = 2'b00;
                active_d = 1'b1;
                fcount_d = fcount_q + 16'd1;
                if (launch) begin
                    state_d = S_HEADER;
                    hdr_d   = CONT_WORD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign TX_data      = data_q;
    assign tx_datak     = datak_q;
    assign frame_active = active_q;
    assign frame_count  = fcount_q;
    assign underrun_err = underrun_q;
    assign data_clamped = clamped_q;
endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb/tb_tx_frame_ctrl.sv - self-checking bench for tx_frame_ctrl with a word-stream model and FIFO source
module tb_tx_frame_ctrl;
    localparam int N = 126;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_ready, tx_enable;
    logic [15:0] src_data;
    logic        src_empty;
    logic [8:0]  src_usedw;
    logic        src_rdreq;
    logic [15:0] TX_data;
    logic [1:0]  tx_datak;
    logic        frame_active;
    logic [15:0] frame_count;
    logic        underrun_err, data_clamped;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    tx_frame_ctrl dut (
        .tx_std_clkout(clk),
        .rst          (rst),
        .tx_ready     (tx_ready),
        .tx_enable    (tx_enable),
        .src_data     (src_data),
        .src_empty    (src_empty),
        .src_usedw    (src_usedw),
        .src_rdreq    (src_rdreq),
        .TX_data      (TX_data),
        .tx_datak     (tx_datak),
        .frame_active (frame_active),
        .frame_count  (frame_count),
        .underrun_err (underrun_err),
        .data_clamped (data_clamped)
    );

    always #5 clk = ~clk;

    // Show-ahead source FIFO; starve makes it look empty without losing words.
    logic [15:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;
    bit starve = 1'b0;
    bit flush  = 1'b0;

    assign src_empty = starve || (wr_ptr == rd_ptr);
    assign src_data  = mem[rd_ptr[11:0]];
    assign src_usedw = 9'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (src_rdreq && !src_empty) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr_ptr[11:0]] = v;
        wr_ptr++;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pops(input int target, input string name);
        int n = 0;
        while (pops < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(pops >= target), 32'd1);
    endtask

    // Word-stream model: m_pos says what the next word on the link must be.
    // -2 idle, -1 header, 0..N-1 next payload index, N trailer.
    int          m_pos = -2;
    logic [15:0] m_hdr = 16'hDEAD;
    logic [15:0] m_fc  = '0;
    logic        m_und = 1'b0, m_clamp = 1'b0;
    logic [15:0] e_data   = 16'h50BC;
    logic [1:0]  e_datak  = 2'b01;
    logic        e_active = 1'b0;

    always @(posedge clk) begin
        logic launch;
        launch = tx_ready && tx_enable && (src_usedw >= 9'd126);
        if (rst) begin
            m_pos = -2; m_fc = '0; m_und = 1'b0; m_clamp = 1'b0;
            e_data = 16'h50BC; e_datak = 2'b01; e_active = 1'b0;
        end else begin
            check("src_rdreq", 32'(src_rdreq), 32'(m_pos >= 0 && m_pos < N && !src_empty));
            e_data   = 16'h50BC;
            e_datak  = 2'b01;
            e_active = (m_pos != -2);
            if (m_pos == -2) begin
                if (launch) begin m_pos = -1; m_hdr = 16'hDEAD; end
            end else if (m_pos == -1) begin
                e_data = m_hdr; e_datak = 2'b00; m_pos = 0;
            end else if (m_pos < N) begin
                if (!src_empty) begin
                    e_datak = 2'b00;
                    if (src_data == 16'h7FFF) begin e_data = 16'h7FFE; m_clamp = 1'b1; end
                    else e_data = src_data;
                    m_pos++;
                end else begin
                    m_und = 1'b1;
                end
            end else begin
                e_data = 16'h7FFF; e_datak = 2'b00; m_fc = m_fc + 16'd1;
                if (launch) begin m_pos = -1; m_hdr = 16'hBEEF; end
                else m_pos = -2;
            end
        end
    end

    logic [15:0] cap[$];
    int          cap_cyc[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        check("TX_data", 32'(TX_data), 32'(e_data));
        check("tx_datak", 32'(tx_datak), 32'(e_datak));
        check("frame_active", 32'(frame_active), 32'(e_active));
        check("frame_count", 32'(frame_count), 32'(m_fc));
        check("underrun_err", 32'(underrun_err), 32'(m_und));
        check("data_clamped", 32'(data_clamped), 32'(m_clamp));
        if (tx_datak == 2'b00) begin
            cap.push_back(TX_data);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic check_reset_literals(input string tag);
        check({tag, "_data"}, 32'(TX_data), 32'h50BC);
        check({tag, "_datak"}, 32'(tx_datak), 32'h1);
        check({tag, "_rdreq"}, 32'(src_rdreq), 32'h0);
        check({tag, "_active"}, 32'(frame_active), 32'h0);
        check({tag, "_fcount"}, 32'(frame_count), 32'h0);
        check({tag, "_underrun"}, 32'(underrun_err), 32'h0);
        check({tag, "_clamped"}, 32'(data_clamped), 32'h0);
    endtask

    function automatic int seq_errs(input int first_idx, input int first_val, input int n);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (cap[first_idx + i] !== 16'(first_val + i)) e++;
        return e;
    endfunction

    initial begin
        int t0;
        int e;
        rst = 1'b1; tx_ready = 1'b1; tx_enable = 1'b1;
        for (int i = 0; i < N; i++) push(16'(i));
        run(2);
        check_reset_literals("reset");

        // single isolated frame
        rst = 1'b0;
        cap.delete(); cap_cyc.delete();
        run(140);
        check("t1_len", cap.size(), 128);
        check("t1_start", 32'(cap[0]), 32'hDEAD);
        check("t1_payload", seq_errs(1, 0, N), 0);
        check("t1_end", 32'(cap[127]), 32'h7FFF);
        check("t1_first_idle", 32'(cap_cyc[0] >= 2), 32'd1);
        check("t1_pops", pops, 126);
        check("t1_fcount", 32'(frame_count), 32'd1);
        check("t1_idle_after", 32'(TX_data), 32'h50BC);

        // back-to-back frames
        cap.delete(); cap_cyc.delete();
        for (int i = 0; i < 2 * N; i++) push(16'(16'h100 + i));
        run(280);
        check("t2_len", cap.size(), 256);
        check("t2_start", 32'(cap[0]), 32'hDEAD);
        check("t2_end0", 32'(cap[127]), 32'h7FFF);
        check("t2_cont", 32'(cap[128]), 32'hBEEF);
        check("t2_gap", cap_cyc[128] - cap_cyc[127], 1);
        check("t2_payload0", seq_errs(1, 16'h100, N), 0);
        check("t2_payload1", seq_errs(129, 16'h17E, N), 0);
        check("t2_end1", 32'(cap[255]), 32'h7FFF);
        check("t2_fcount", 32'(frame_count), 32'd3);
        check("t2_pops", pops, 378);

        // launch threshold and latency
        cap.delete(); cap_cyc.delete();
        for (int i = 0; i < N - 1; i++) push(16'(16'h200 + i));
        run(20);
        check("t3_no_frame", cap.size(), 0);
        check("t3_no_pops", pops, 378);
        push(16'h27D);
        t0 = cyc;
        run(3);
        check("t3_started", 32'(cap.size() >= 1), 32'd1);
        check("t3_start_word", 32'(cap[0]), 32'hDEAD);
        check("t3_latency", cap_cyc[0] - t0, 2);
        run(135);
        check("t3_payload", seq_errs(1, 16'h200, N), 0);
        check("t3_fcount", 32'(frame_count), 32'd4);

        // mid-payload underrun of three cycles after word 60
        cap.delete(); cap_cyc.delete();
        for (int i = 0; i < N; i++) push(16'(16'h300 + i));
        wait_pops(504 + 60, "t4_wait60");
        starve = 1'b1;
        run(3);
        starve = 1'b0;
        run(100);
        check("t4_len", cap.size(), 128);
        check("t4_payload", seq_errs(1, 16'h300, N), 0);
        check("t4_end", 32'(cap[127]), 32'h7FFF);
        check("t4_span", cap_cyc[127] - cap_cyc[0], 130);
        check("t4_underrun", 32'(underrun_err), 32'd1);
        check("t4_fcount", 32'(frame_count), 32'd5);

        // END_WORD inside the payload, tx_enable dropped mid-frame
        cap.delete(); cap_cyc.delete();
        for (int i = 0; i < N; i++) push(i == 10 ? 16'h7FFF : 16'(16'h400 + i));
        wait_pops(630 + 50, "t5_wait50");
        tx_enable = 1'b0;
        run(100);
        e = 0;
        for (int i = 0; i < N; i++)
            if (cap[1 + i] !== (i == 10 ? 16'h7FFE : 16'(16'h400 + i))) e++;
        check("t5_len", cap.size(), 128);
        check("t5_clamped_word", 32'(cap[11]), 32'h7FFE);
        check("t5_payload", e, 0);
        check("t5_end", 32'(cap[127]), 32'h7FFF);
        check("t5_clamp_flag", 32'(data_clamped), 32'd1);
        check("t5_fcount", 32'(frame_count), 32'd6);
        tx_enable = 1'b1;

        // asynchronous reset mid-payload
        for (int i = 0; i < N; i++) push(16'(16'h500 + i));
        wait_pops(756 + 40, "t6_wait40");
        rst = 1'b1;
        #1;
        check_reset_literals("t6_async");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t6_no_pops_in_reset", pops, 796);
        @(negedge clk);
        rst = 1'b0;
        cap.delete(); cap_cyc.delete();
        for (int i = 0; i < N; i++) push(16'(16'h600 + i));
        run(140);
        check("t6_len", cap.size(), 128);
        check("t6_start", 32'(cap[0]), 32'hDEAD);
        check("t6_payload", seq_errs(1, 16'h600, N), 0);
        check("t6_end", 32'(cap[127]), 32'h7FFF);
        check("t6_fcount", 32'(frame_count), 32'd1);
        check("t6_flags", 32'({underrun_err, data_clamped}), 32'd0);
        check("t6_pops", pops, 922);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end
endmodule
